// File: rtl/float_mul_pipe_norm_stage.sv
// float_mul_pipe_norm_stage
//   Last two stages of the pipelined single-precision multiplier.
//   N1 normalizes the 48-bit significand product (right shift on carry,
//   left shift for denormal operands, right shift into the denormal range).
//   N2 rounds, detects overflow/underflow and packs the IEEE-754 word.
//   One common enable advances both stages; valid travels with the data.
// Ports
//   clk, rst (async, active high), en (advance), in_valid
//   n_rm, n_sign, n_exp10, n_is_inf_nan, n_inf_nan_frac, n_z : operation fields
//   s (packed result), out_valid, ovf, unf, inexact
module float_mul_pipe_norm_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        in_valid,
    input  logic [1:0]  n_rm,
    input  logic        n_sign,
    input  logic [9:0]  n_exp10,
    input  logic        n_is_inf_nan,
    input  logic [22:0] n_inf_nan_frac,
    input  logic [47:0] n_z,
    output logic [31:0] s,
    output logic        out_valid,
    output logic        ovf,
    output logic        unf,
    output logic        inexact
);

    // N1 combinational normalize
    logic signed [9:0] e_in, e_a, sh, amt, lz_s;
    logic [5:0]  lz;
    logic        found;
    logic [47:0] m;
    logic [73:0] shr;
    logic [23:0] c_sig;
    logic        c_g, c_st, c_zero;
    logic signed [9:0] c_exp;

    always_comb begin
        e_in  = n_exp10;
        lz    = '0;
        found = 1'b0;
        for (int i = 46; i >= 0; i--) begin
            if (!found) begin
                if (n_z[i]) found = 1'b1;
                else        lz = lz + 6'd1;
            end
        end
        lz_s = {4'b0, lz};
        sh   = '0;
        amt  = '0;
        shr  = '0;
        if (n_z[47]) begin
            // integer bit already at 47; bit 0 lands in sticky below
            m   = n_z;
            e_a = e_in + 10'sd1;
        end else begin
            // left shift limited so the exponent never drops below 1
            if (e_in > 10'sd1)
                sh = (lz_s > e_in - 10'sd1) ? e_in - 10'sd1 : lz_s;
            m   = {n_z[46:0], 1'b0} << sh[5:0];
            e_a = e_in - sh;
        end
        c_sig = m[47:24];
        c_g   = m[23];
        c_st  = |m[22:0];
        c_exp = e_a;
        if (e_a <= 10'sd0) begin
            amt   = 10'sd1 - e_a;
            c_exp = '0;
            if (amt >= 10'sd26) begin
                c_sig = '0;
                c_g   = 1'b0;
                c_st  = |m;
            end else begin
                // 26 zero pad bits keep every shifted-out bit visible to sticky
                shr   = {m, 26'b0} >> amt[4:0];
                c_sig = shr[73:50];
                c_g   = shr[49];
                c_st  = |shr[48:0];
            end
        end else if (!m[47]) begin
            // left shift was limited at exponent 1: value is denormal
            c_exp = '0;
        end
        c_zero = (n_z == 48'd0);
    end

    // N1 register
    logic              r1_valid, r1_sign, r1_g, r1_st, r1_inf_nan, r1_zero;
    logic [1:0]        r1_rm;
    logic [23:0]       r1_sig;
    logic signed [9:0] r1_exp;
    logic [22:0]       r1_frac;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r1_valid   <= 1'b0;
            r1_sign    <= 1'b0;
            r1_g       <= 1'b0;
            r1_st      <= 1'b0;
            r1_inf_nan <= 1'b0;
            r1_zero    <= 1'b0;
            r1_rm      <= '0;
            r1_sig     <= '0;
            r1_exp     <= '0;
            r1_frac    <= '0;
        end else if (en) begin
            r1_valid   <= in_valid;
            r1_sign    <= n_sign;
            r1_g       <= c_g;
            r1_st      <= c_st;
            r1_inf_nan <= n_is_inf_nan;
            r1_zero    <= c_zero;
            r1_rm      <= n_rm;
            r1_sig     <= c_sig;
            r1_exp     <= c_exp;
            r1_frac    <= n_inf_nan_frac;
        end
    end

    // N2 combinational round/pack
    logic              inc, c_inexact, c_ovf, c_unf;
    logic [24:0]       sum;
    logic [22:0]       frac_r;
    logic signed [9:0] exp_r;
    logic [31:0]       c_s;

    always_comb begin
        case (r1_rm)
            2'b00:   inc = r1_g & (r1_st | r1_sig[0]);
            2'b01:   inc = r1_sign & (r1_g | r1_st);
            2'b10:   inc = ~r1_sign & (r1_g | r1_st);
            default: inc = 1'b0;
        endcase
        sum = {1'b0, r1_sig} + {24'b0, inc};
        if (sum[24]) begin
            frac_r = sum[23:1];
            exp_r  = r1_exp + 10'sd1;
        end else begin
            frac_r = sum[22:0];
            exp_r  = (r1_exp == 10'sd0 && sum[23]) ? 10'sd1 : r1_exp;
        end
        c_inexact = r1_g | r1_st;
        c_unf     = (r1_exp == 10'sd0) & c_inexact;
        c_ovf     = 1'b0;
        c_s       = {r1_sign, exp_r[7:0], frac_r};
        if (r1_inf_nan) begin
            c_s       = {r1_sign, 8'hFF, r1_frac};
            c_inexact = 1'b0;
            c_unf     = 1'b0;
        end else if (r1_zero) begin
            c_s       = {r1_sign, 31'b0};
            c_inexact = 1'b0;
            c_unf     = 1'b0;
        end else if (exp_r >= 10'sd255) begin
            c_ovf     = 1'b1;
            c_inexact = 1'b1;
            c_unf     = 1'b0;
            // modes rounding away from the sign's direction saturate to max finite
            if (r1_rm == 2'b00 || (r1_rm == 2'b01 && r1_sign) || (r1_rm == 2'b10 && !r1_sign))
                c_s = {r1_sign, 8'hFF, 23'h0};
            else
                c_s = {r1_sign, 8'hFE, 23'h7FFFFF};
        end
    end

    // N2 register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s         <= '0;
            out_valid <= 1'b0;
            ovf       <= 1'b0;
            unf       <= 1'b0;
            inexact   <= 1'b0;
        end else if (en) begin
            s         <= c_s;
            out_valid <= r1_valid;
            ovf       <= c_ovf;
            unf       <= c_unf;
            inexact   <= c_inexact;
        end
    end

endmodule

// File: tb/tb_float_mul_pipe_norm_stage.sv
module tb_float_mul_pipe_norm_stage;

    logic        clk = 1'b0;
    logic        rst, en, in_valid, n_sign, n_is_inf_nan;
    logic [1:0]  n_rm;
    logic [9:0]  n_exp10;
    logic [22:0] n_inf_nan_frac;
    logic [47:0] n_z;
    logic [31:0] s;
    logic        out_valid, ovf, unf, inexact;

    float_mul_pipe_norm_stage dut (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid),
        .n_rm(n_rm), .n_sign(n_sign), .n_exp10(n_exp10),
        .n_is_inf_nan(n_is_inf_nan), .n_inf_nan_frac(n_inf_nan_frac), .n_z(n_z),
        .s(s), .out_valid(out_valid), .ovf(ovf), .unf(unf), .inexact(inexact)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] s;
        logic [2:0]  f;   // {ovf, unf, inexact}
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    endtask

    task automatic check_out();
        exp_t e;
        if (out_valid === 1'b1) begin
            n_checks++;
            assert (q.size() > 0) n_pass++;
            else $error("FAIL spurious_valid observed=1 expected=0");
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("result_s", s, e.s);
                chk("flags", {29'b0, ovf, unf, inexact}, {29'b0, e.f});
            end
        end
    endtask

    task automatic tick();
        logic en_at_edge;
        en_at_edge = en;
        @(posedge clk);
        #1;
        if (en_at_edge) check_out();
    endtask

    task automatic issue(logic [1:0] rm, logic sg, logic [9:0] e, logic [47:0] z,
                         logic inf_nan, logic [22:0] frac,
                         logic [31:0] es, logic [2:0] ef);
        en = 1'b1; in_valid = 1'b1;
        n_rm = rm; n_sign = sg; n_exp10 = e; n_z = z;
        n_is_inf_nan = inf_nan; n_inf_nan_frac = frac;
        q.push_back('{s: es, f: ef});
        tick();
    endtask

    task automatic idle();
        en = 1'b1; in_valid = 1'b0;
        n_z = 48'h123456789ABC; n_exp10 = 10'd77;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; en = 1'b0; in_valid = 1'b0; n_rm = 2'b00; n_sign = 1'b0;
        n_exp10 = '0; n_is_inf_nan = 1'b0; n_inf_nan_frac = '0; n_z = '0;
        #12;
        chk("reset_s", s, 32'h0);
        chk("reset_valid", {31'b0, out_valid}, 32'h0);
        chk("reset_flags", {29'b0, ovf, unf, inexact}, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // basic, tie rounding, directed modes
        issue(2'b00, 1'b0, 10'd127, 48'h900000000000, 1'b0, 23'h0, 32'h40100000, 3'b000);
        issue(2'b00, 1'b0, 10'd127, 48'h400000400000, 1'b0, 23'h0, 32'h3F800000, 3'b001);
        issue(2'b10, 1'b0, 10'd127, 48'h400000400000, 1'b0, 23'h0, 32'h3F800001, 3'b001);
        issue(2'b11, 1'b0, 10'd127, 48'h400000400000, 1'b0, 23'h0, 32'h3F800000, 3'b001);
        issue(2'b01, 1'b1, 10'd127, 48'h400000400000, 1'b0, 23'h0, 32'hBF800001, 3'b001);
        issue(2'b00, 1'b0, 10'd127, 48'h400000C00000, 1'b0, 23'h0, 32'h3F800002, 3'b001);
        // rounding carry-out
        issue(2'b00, 1'b0, 10'd127, 48'h7FFFFFC00000, 1'b0, 23'h0, 32'h40000000, 3'b001);
        // overflow in each mode
        issue(2'b00, 1'b0, 10'd300, 48'h400000000000, 1'b0, 23'h0, 32'h7F800000, 3'b101);
        issue(2'b11, 1'b0, 10'd300, 48'h400000000000, 1'b0, 23'h0, 32'h7F7FFFFF, 3'b101);
        issue(2'b01, 1'b0, 10'd300, 48'h400000000000, 1'b0, 23'h0, 32'h7F7FFFFF, 3'b101);
        issue(2'b10, 1'b1, 10'd300, 48'h400000000000, 1'b0, 23'h0, 32'hFF7FFFFF, 3'b101);
        // denormal output, exact
        issue(2'b00, 1'b0, 10'h3F6, 48'h400000000000, 1'b0, 23'h0, 32'h00001000, 3'b000);
        // inf/nan bypass
        issue(2'b01, 1'b0, 10'd127, 48'h400000000000, 1'b1, 23'h400000, 32'h7FC00000, 3'b000);
        // zero product
        issue(2'b00, 1'b1, 10'd50, 48'h0, 1'b0, 23'h0, 32'h80000000, 3'b000);
        // denormal operand: full left shift, then shift limited at exponent 1
        issue(2'b00, 1'b0, 10'd127, 48'h100000000000, 1'b0, 23'h0, 32'h3E800000, 3'b000);
        issue(2'b00, 1'b0, 10'd2, 48'h100000000000, 1'b0, 23'h0, 32'h00400000, 3'b000);
        // denormal rounds up into the normal range
        issue(2'b00, 1'b0, 10'd0, 48'h7FFFFF800000, 1'b0, 23'h0, 32'h00800000, 3'b011);
        // shift far past the significand: sticky only
        issue(2'b00, 1'b0, 10'h338, 48'h400000000000, 1'b0, 23'h0, 32'h00000000, 3'b011);
        issue(2'b10, 1'b0, 10'h338, 48'h400000000000, 1'b0, 23'h0, 32'h00000001, 3'b011);
        idle();
        idle();
        chk("drained", q.size(), 32'd0);

        // stall mid-stream
        issue(2'b00, 1'b0, 10'd127, 48'h900000000000, 1'b0, 23'h0, 32'h40100000, 3'b000);
        issue(2'b10, 1'b0, 10'd127, 48'h400000400000, 1'b0, 23'h0, 32'h3F800001, 3'b001);
        en = 1'b0; in_valid = 1'b1; n_z = 48'hFFFFFFFFFFFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_s", s, 32'h40100000);
            chk("stall_valid", {31'b0, out_valid}, 32'h1);
        end
        idle();
        idle();
        chk("stall_drained", q.size(), 32'd0);
        chk("stall_idle_valid", {31'b0, out_valid}, 32'h0);

        // reset mid-stream
        issue(2'b00, 1'b0, 10'd127, 48'h7FFFFFC00000, 1'b0, 23'h0, 32'h40000000, 3'b001);
        issue(2'b00, 1'b0, 10'd300, 48'h400000000000, 1'b0, 23'h0, 32'h7F800000, 3'b101);
        en = 1'b1; in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_mid_s", s, 32'h0);
        q.delete();
        #2 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_valid", {31'b0, out_valid}, 32'h0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
